// File: rtl/instruction_memory_controller.sv
// Round-robin instruction fetch arbiter over a single-ported store.
// Fixed-latency pipelined responses; program-load write has port priority.
module instruction_memory_controller #(
  parameter int NUM_CHANNELS = 8,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CHANNELS-1:0]            read_valid,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] read_address,
  output logic [NUM_CHANNELS-1:0]            read_ready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] read_data,
  input  logic                               prog_write_valid,
  input  logic [ADDR_WIDTH-1:0]              prog_write_address,
  input  logic [DATA_WIDTH-1:0]              prog_write_data,
  output logic                               addr_error
);

  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int MA_W = $clog2(DEPTH);

  typedef struct packed {
    logic                  valid;
    logic [CH_W-1:0]       id;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [CH_W-1:0]         rr_ptr;
  logic [NUM_CHANNELS-1:0] inflight;
  logic [NUM_CHANNELS-1:0] eligible;
  logic [NUM_CHANNELS-1:0] grant_vec;
  logic [CH_W-1:0]         cand;
  logic [CH_W-1:0]         win;
  logic [CH_W-1:0]         ptr_nxt;
  logic                    found;
  logic                    grant;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    rd_ok;
  logic                    wr_ok;
  logic                    err_set;
  entry_t                  grant_e;
  entry_t                  tail;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 64'(a) < 64'(DEPTH);
  endfunction

  assign eligible = read_valid & ~inflight;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      cand = CH_W'((int'(rr_ptr) + k) % NUM_CHANNELS);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // The write owns the single port, so it suppresses any grant.
  assign grant = found && !prog_write_valid;

  assign ptr_nxt = (win == CH_W'(NUM_CHANNELS - 1)) ?
                   '0 : win + 1'b1;

  always_comb begin
    rd_addr   = '0;
    grant_vec = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (win == CH_W'(i)) begin
        rd_addr      = read_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        grant_vec[i] = grant;
      end
    end
  end

  assign rd_ok   = in_range(rd_addr);
  assign wr_ok   = in_range(prog_write_address);
  assign err_set = (grant && !rd_ok) ||
                   (prog_write_valid && !wr_ok);

  always_comb begin
    grant_e       = '0;
    grant_e.valid = grant;
    grant_e.id    = win;
    grant_e.data  = rd_ok ? mem[rd_addr[MA_W-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (prog_write_valid && wr_ok)
      mem[prog_write_address[MA_W-1:0]] <= prog_write_data;
  end

  // Output registers form the final stage; only the earlier ones live here.
  generate
    if (READ_LATENCY == 1) begin : g_nopipe
      assign tail = grant_e;
    end else begin : g_pipe
      entry_t pipe_q [READ_LATENCY-1];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < READ_LATENCY - 1; k++)
            pipe_q[k] <= '0;
        end else begin
          pipe_q[0] <= grant_e;
          for (int k = 1; k < READ_LATENCY - 1; k++)
            pipe_q[k] <= pipe_q[k-1];
        end
      end
      assign tail = pipe_q[READ_LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      inflight   <= '0;
      read_ready <= '0;
      read_data  <= '0;
      addr_error <= 1'b0;
    end else begin
      if (grant)
        rr_ptr <= ptr_nxt;
      inflight <= (inflight & ~read_ready) | grant_vec;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        read_ready[i] <= tail.valid && (tail.id == CH_W'(i));
        if (tail.valid && (tail.id == CH_W'(i)))
          read_data[i*DATA_WIDTH +: DATA_WIDTH] <= tail.data;
      end
      if (err_set)
        addr_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_memory_controller.sv
// Directed bench for instruction_memory_controller.
// Hand-computed latency, arbitration and range expectations.
module tb_instruction_memory_controller;

  localparam int N  = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            reset;
  logic [N-1:0]    read_valid;
  logic [N*AW-1:0] read_address;
  logic [N-1:0]    read_ready;
  logic [N*DW-1:0] read_data;
  logic            prog_write_valid;
  logic [AW-1:0]   prog_write_address;
  logic [DW-1:0]   prog_write_data;
  logic            addr_error;

  int total;
  int bad;

  instruction_memory_controller #(
    .NUM_CHANNELS(N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH(256),
    .READ_LATENCY(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .read_valid(read_valid),
    .read_address(read_address),
    .read_ready(read_ready),
    .read_data(read_data),
    .prog_write_valid(prog_write_valid),
    .prog_write_address(prog_write_address),
    .prog_write_data(prog_write_data),
    .addr_error(addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rdata(input int ch);
    return read_data[ch*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int ch, input logic [AW-1:0] a);
    read_address[ch*AW +: AW] = a;
  endtask

  task automatic apply_reset();
    read_valid       = '0;
    prog_write_valid = 1'b0;
    reset            = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #2;
    total++;
    if (read_ready !== '0) begin
      bad++;
      $display("FAIL reset_ready: got %h want 0", read_ready);
    end
    total++;
    if (read_data !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", read_data);
    end
    total++;
    if (addr_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_err: got %b want 0", addr_error);
    end
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (read_ready !== '0) begin
      bad++;
      $display("FAIL reset_idle: got %h want 0", read_ready);
    end
  endtask

  task automatic load_program();
    for (int i = 0; i < 8; i++) begin
      prog_write_valid   = 1'b1;
      prog_write_address = AW'(i);
      prog_write_data    = 32'h1000 + DW'(i);
      tick();
    end
    prog_write_valid = 1'b0;
  endtask

  task automatic test_single_read();
    set_addr(3, 32'd5);
    read_valid = 8'b0000_1000;
    for (int t = 1; t <= 3; t++) begin
      tick();
      total++;
      if (read_ready !== ((t == 2) ? 8'b0000_1000 : 8'h00)) begin
        bad++;
        $display("FAIL single_ready t%0d: got %h", t, read_ready);
      end
      if (t >= 2) begin
        total++;
        if (rdata(3) !== 32'h1005) begin
          bad++;
          $display("FAIL single_data t%0d: got %h want 1005",
                   t, rdata(3));
        end
      end
      if (t == 2) read_valid = '0;
    end
  endtask

  task automatic test_all_channels();
    logic [N-1:0] exp;
    apply_reset();
    for (int i = 0; i < N; i++) set_addr(i, AW'(i));
    read_valid = '1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      exp = (t >= 2 && t <= 9) ? N'(1 << (t - 2)) : '0;
      total++;
      if (read_ready !== exp) begin
        bad++;
        $display("FAIL rr_ready t%0d: got %h want %h",
                 t, read_ready, exp);
      end
      if (t >= 2 && t <= 9) begin
        total++;
        if (rdata(t - 2) !== 32'h1000 + DW'(t - 2)) begin
          bad++;
          $display("FAIL rr_data ch%0d: got %h want %h", t - 2,
                   rdata(t - 2), 32'h1000 + DW'(t - 2));
        end
        read_valid[t-2] = 1'b0;
      end
    end
  endtask

  task automatic test_hold_valid();
    set_addr(0, 32'd2);
    read_valid = 8'b0000_0001;
    for (int t = 1; t <= 8; t++) begin
      tick();
      total++;
      if (read_ready !== ((t == 2 || t == 7) ? 8'h01 : 8'h00)) begin
        bad++;
        $display("FAIL hold_ready t%0d: got %h", t, read_ready);
      end
      if (t == 2) begin
        total++;
        if (rdata(0) !== 32'h1002) begin
          bad++;
          $display("FAIL hold_data1: got %h want 1002", rdata(0));
        end
      end
      if (t == 7) begin
        total++;
        if (rdata(0) !== 32'h1006) begin
          bad++;
          $display("FAIL hold_data2: got %h want 1006", rdata(0));
        end
        read_valid = '0;
      end
      if (t == 3) read_valid = '0;
      if (t == 5) begin
        set_addr(0, 32'd6);
        read_valid = 8'b0000_0001;
      end
    end
  endtask

  task automatic test_write_priority();
    prog_write_valid   = 1'b1;
    prog_write_address = 32'd9;
    prog_write_data    = 32'hDEAD_BEEF;
    set_addr(1, 32'd9);
    set_addr(2, 32'd3);
    read_valid = 8'b0000_0110;
    for (int t = 1; t <= 5; t++) begin
      tick();
      if (t == 1) prog_write_valid = 1'b0;
      total++;
      if (read_ready !== ((t == 3) ? 8'h02 :
                          (t == 4) ? 8'h04 : 8'h00)) begin
        bad++;
        $display("FAIL wpri_ready t%0d: got %h", t, read_ready);
      end
      if (t == 3) begin
        total++;
        if (rdata(1) !== 32'hDEAD_BEEF) begin
          bad++;
          $display("FAIL wpri_raw: got %h want deadbeef", rdata(1));
        end
        read_valid[1] = 1'b0;
      end
      if (t == 4) begin
        total++;
        if (rdata(2) !== 32'h1003) begin
          bad++;
          $display("FAIL wpri_ch2: got %h want 1003", rdata(2));
        end
        read_valid[2] = 1'b0;
      end
    end
  endtask

  task automatic test_out_of_range();
    total++;
    if (addr_error !== 1'b0) begin
      bad++;
      $display("FAIL oor_pre: got %b want 0", addr_error);
    end
    set_addr(4, 32'd300);
    read_valid = 8'b0001_0000;
    tick();
    total++;
    if (addr_error !== 1'b1) begin
      bad++;
      $display("FAIL oor_err: got %b want 1", addr_error);
    end
    tick();
    total++;
    if (read_ready !== 8'h10 || rdata(4) !== '0) begin
      bad++;
      $display("FAIL oor_read: got rdy %h data %h want 10/0",
               read_ready, rdata(4));
    end
    read_valid = '0;
    prog_write_valid   = 1'b1;
    prog_write_address = 32'd256;
    prog_write_data    = 32'hBAD0_0000;
    tick();
    prog_write_valid = 1'b0;
    set_addr(5, 32'd0);
    read_valid = 8'b0010_0000;
    tick();
    tick();
    total++;
    if (read_ready !== 8'h20 || rdata(5) !== 32'h1000) begin
      bad++;
      $display("FAIL oor_drop: got rdy %h data %h want 20/1000",
               read_ready, rdata(5));
    end
    read_valid = '0;
    repeat (3) tick();
    total++;
    if (addr_error !== 1'b1) begin
      bad++;
      $display("FAIL oor_sticky: got %b want 1", addr_error);
    end
  endtask

  task automatic test_reset_inflight();
    set_addr(6, 32'd1);
    set_addr(7, 32'd2);
    read_valid = 8'b1100_0000;
    tick();
    total++;
    if (read_ready !== '0) begin
      bad++;
      $display("FAIL rst_pre: got %h want 0", read_ready);
    end
    reset = 1'b1;
    #1;
    total++;
    if (read_ready !== '0 || read_data !== '0 || addr_error !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: rdy %h data %h err %b want 0",
               read_ready, read_data, addr_error);
    end
    read_valid = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      total++;
      if (read_ready !== '0) begin
        bad++;
        $display("FAIL rst_ghost t%0d: got %h want 0", t, read_ready);
      end
    end
    set_addr(0, 32'd7);
    read_valid = 8'b0000_0001;
    tick();
    tick();
    total++;
    if (read_ready !== 8'h01 || rdata(0) !== 32'h1007) begin
      bad++;
      $display("FAIL rst_store: rdy %h data %h want 01/1007",
               read_ready, rdata(0));
    end
    read_valid = '0;
    tick();
  endtask

  initial begin
    total              = 0;
    bad                = 0;
    reset              = 1'b0;
    read_valid         = '0;
    read_address       = '0;
    prog_write_valid   = 1'b0;
    prog_write_address = '0;
    prog_write_data    = '0;
    test_reset();
    load_program();
    test_single_read();
    test_all_channels();
    test_hold_valid();
    test_write_priority();
    test_out_of_range();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
